// File: rtl/hamm_scrub_ctrl.sv
// Access sequencer for a Hamming(12,8) protected memory: host port plus a
// background scrub engine that writes back bytes the decoder reports as corrected.
module hamm_scrub_ctrl #(
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 8,
   parameter int SCRUB_PERIOD = 64,
   parameter int RD_LAT       = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              host_req,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_add,
   input  logic [DATA_W-1:0] host_din,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_dout,
   output logic              host_err,
   input  logic              scrub_en,
   output logic              mem_en,
   output logic              mem_red_wr,
   output logic [ADDR_W-1:0] mem_add,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] dec_data,
   input  logic              dec_err,
   output logic              scrub_busy,
   output logic [7:0]        scrub_fix_cnt,
   output logic              scrub_pass
);

   typedef enum logic [2:0] {
      IDLE, H_WR, H_RD, H_WAIT, H_WB, S_RD, S_WAIT, S_WB
   } state_t;

   localparam logic [15:0]       RELOAD  = 16'(SCRUB_PERIOD - 1);
   localparam logic [1:0]        LAT_M1  = 2'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] PTR_MAX = '1;

   state_t              state_q, state_d;
   logic [1:0]          lat_q, lat_d;
   logic [ADDR_W-1:0]   h_add_q, h_add_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [15:0]         timer_q, timer_d;
   logic                pending_q, pending_d;
   logic [7:0]          fix_q, fix_d;
   logic                host_ack_q, host_ack_d;
   logic [DATA_W-1:0]   host_dout_q, host_dout_d;
   logic                host_err_q, host_err_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_red_wr_q, mem_red_wr_d;
   logic [ADDR_W-1:0]   mem_add_q, mem_add_d;
   logic [DATA_W-1:0]   mem_din_q, mem_din_d;
   logic                busy_q, busy_d;
   logic                pass_q, pass_d;

   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      h_add_d      = h_add_q;
      ptr_d        = ptr_q;
      timer_d      = timer_q;
      pending_d    = pending_q;
      fix_d        = fix_q;
      host_ack_d   = 1'b0;
      host_dout_d  = host_dout_q;
      host_err_d   = host_err_q;
      mem_en_d     = 1'b0;
      mem_red_wr_d = 1'b0;
      mem_add_d    = mem_add_q;
      mem_din_d    = mem_din_q;
      pass_d       = 1'b0;

      // An expiry while a step is already pending is dropped, not queued.
      if (!scrub_en) begin
         timer_d   = RELOAD;
         pending_d = 1'b0;
      end else if (timer_q == 16'd0) begin
         timer_d   = RELOAD;
         pending_d = 1'b1;
      end else begin
         timer_d = timer_q - 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (host_req && !host_ack_q) begin
               h_add_d   = host_add;
               mem_en_d  = 1'b1;
               mem_add_d = host_add;
               if (host_wr) begin
                  state_d      = H_WR;
                  mem_red_wr_d = 1'b1;
                  mem_din_d    = host_din;
               end else begin
                  state_d = H_RD;
               end
            end else if (pending_q && scrub_en) begin
               state_d   = S_RD;
               pending_d = 1'b0;
               mem_en_d  = 1'b1;
               mem_add_d = ptr_q;
            end
         end
         H_WR: begin
            state_d    = IDLE;
            host_ack_d = 1'b1;
         end
         H_RD: begin
            state_d = H_WAIT;
            lat_d   = LAT_M1;
         end
         H_WAIT: begin
            if (lat_q == 2'd0) begin
               host_dout_d = dec_data;
               host_err_d  = dec_err;
               if (dec_err) begin
                  state_d      = H_WB;
                  mem_en_d     = 1'b1;
                  mem_red_wr_d = 1'b1;
                  mem_add_d    = h_add_q;
                  mem_din_d    = dec_data;
               end else begin
                  state_d    = IDLE;
                  host_ack_d = 1'b1;
               end
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         H_WB: begin
            if (fix_q != 8'hFF) fix_d = fix_q + 8'd1;
            state_d    = IDLE;
            host_ack_d = 1'b1;
         end
         S_RD: begin
            state_d = S_WAIT;
            lat_d   = LAT_M1;
         end
         S_WAIT: begin
            if (lat_q == 2'd0) begin
               if (dec_err) begin
                  state_d      = S_WB;
                  mem_en_d     = 1'b1;
                  mem_red_wr_d = 1'b1;
                  mem_add_d    = ptr_q;
                  mem_din_d    = dec_data;
               end else begin
                  state_d = IDLE;
                  ptr_d   = ptr_q + 1'b1;
                  pass_d  = (ptr_q == PTR_MAX);
               end
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         S_WB: begin
            if (fix_q != 8'hFF) fix_d = fix_q + 8'd1;
            state_d = IDLE;
            ptr_d   = ptr_q + 1'b1;
            pass_d  = (ptr_q == PTR_MAX);
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == S_RD) || (state_d == S_WAIT) || (state_d == S_WB);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q      <= IDLE;
         lat_q        <= 2'd0;
         h_add_q      <= '0;
         ptr_q        <= '0;
         timer_q      <= RELOAD;
         pending_q    <= 1'b0;
         fix_q        <= 8'd0;
         host_ack_q   <= 1'b0;
         host_dout_q  <= '0;
         host_err_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_red_wr_q <= 1'b0;
         mem_add_q    <= '0;
         mem_din_q    <= '0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         h_add_q      <= h_add_d;
         ptr_q        <= ptr_d;
         timer_q      <= timer_d;
         pending_q    <= pending_d;
         fix_q        <= fix_d;
         host_ack_q   <= host_ack_d;
         host_dout_q  <= host_dout_d;
         host_err_q   <= host_err_d;
         mem_en_q     <= mem_en_d;
         mem_red_wr_q <= mem_red_wr_d;
         mem_add_q    <= mem_add_d;
         mem_din_q    <= mem_din_d;
         busy_q       <= busy_d;
         pass_q       <= pass_d;
      end
   end

   assign host_ack      = host_ack_q;
   assign host_dout     = host_dout_q;
   assign host_err      = host_err_q;
   assign mem_en        = mem_en_q;
   assign mem_red_wr    = mem_red_wr_q;
   assign mem_add       = mem_add_q;
   assign mem_din       = mem_din_q;
   assign scrub_busy    = busy_q;
   assign scrub_fix_cnt = fix_q;
   assign scrub_pass    = pass_q;

endmodule

// File: tb/tb_hamm_scrub_ctrl.sv
// Scoreboard bench for hamm_scrub_ctrl: expected memory strobes and host acks
// are queued as stimulus is issued and popped as the DUT produces them.
module tb_hamm_scrub_ctrl;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int PERIOD = 8;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              clr = 1'b0;
   logic              host_req = 1'b0;
   logic              host_wr = 1'b0;
   logic [ADDR_W-1:0] host_add = '0;
   logic [DATA_W-1:0] host_din = '0;
   logic              host_ack;
   logic [DATA_W-1:0] host_dout;
   logic              host_err;
   logic              scrub_en = 1'b0;
   logic              mem_en;
   logic              mem_red_wr;
   logic [ADDR_W-1:0] mem_add;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] dec_data = '0;
   logic              dec_err = 1'b0;
   logic              scrub_busy;
   logic [7:0]        scrub_fix_cnt;
   logic              scrub_pass;

   hamm_scrub_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCRUB_PERIOD(PERIOD), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .clr(clr),
      .host_req(host_req), .host_wr(host_wr), .host_add(host_add), .host_din(host_din),
      .host_ack(host_ack), .host_dout(host_dout), .host_err(host_err),
      .scrub_en(scrub_en),
      .mem_en(mem_en), .mem_red_wr(mem_red_wr), .mem_add(mem_add), .mem_din(mem_din),
      .dec_data(dec_data), .dec_err(dec_err),
      .scrub_busy(scrub_busy), .scrub_fix_cnt(scrub_fix_cnt), .scrub_pass(scrub_pass)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] add;
      logic [DATA_W-1:0] din;
   } strobe_t;

   typedef struct packed {
      logic              rd;
      logic [DATA_W-1:0] dout;
      logic              err;
   } ack_t;

   strobe_t strobe_q[$];
   ack_t    ack_q[$];

   logic [DATA_W-1:0] data_tbl [16];
   logic              err_tbl  [16];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Decoder stand-in: presents the table entry for the address being read.
   always @(posedge clk) begin
      #1;
      if (mem_en && !mem_red_wr) begin
         dec_data = data_tbl[mem_add];
         dec_err  = err_tbl[mem_add];
      end
   end

   int                run_id   = 0;
   int                prev_run = -1;
   int                prev_srd = 0;
   int                srd_cnt  = 0;
   int                pass_cnt = 0;
   logic [ADDR_W-1:0] last_sadd = '0;
   strobe_t           mon_s;
   ack_t              mon_a;

   always @(negedge clk) begin
      if (clr) begin
         if (mem_en) begin
            if (strobe_q.size() == 0) begin
               check("strobe_unexpected", 1, 0);
            end else begin
               mon_s = strobe_q.pop_front();
               check("strobe_wr", mem_red_wr, mon_s.wr);
               check("strobe_add", mem_add, mon_s.add);
               if (mon_s.wr) check("strobe_din", mem_din, mon_s.din);
            end
            if (!mem_red_wr && scrub_busy) begin
               if (prev_run == run_id) check("scrub_gap", cyc - prev_srd, PERIOD);
               prev_run  = run_id;
               prev_srd  = cyc;
               last_sadd = mem_add;
               srd_cnt++;
            end
         end
         if (host_ack) begin
            if (ack_q.size() == 0) begin
               check("ack_unexpected", 1, 0);
            end else begin
               mon_a = ack_q.pop_front();
               if (mon_a.rd) begin
                  check("host_dout", host_dout, mon_a.dout);
                  check("host_err", host_err, mon_a.err);
               end
            end
         end
         if (scrub_pass) begin
            pass_cnt++;
            check("pass_after_15", last_sadd, 15);
         end
      end
   end

   int                exp_fix  = 0;
   int                exp_pass = 0;
   logic [ADDR_W-1:0] exp_ptr  = '0;

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   // Call just after a rising edge; leaves one idle cycle after the ack.
   task automatic host_txn(input logic wr, input logic [ADDR_W-1:0] add,
                           input logic [DATA_W-1:0] din, input int exp_lat);
      int n;
      if (wr) begin
         strobe_q.push_back(strobe_t'{wr: 1'b1, add: add, din: din});
         ack_q.push_back(ack_t'{rd: 1'b0, dout: 8'h00, err: 1'b0});
      end else begin
         strobe_q.push_back(strobe_t'{wr: 1'b0, add: add, din: 8'h00});
         if (err_tbl[add]) begin
            strobe_q.push_back(strobe_t'{wr: 1'b1, add: add, din: data_tbl[add]});
            exp_fix = sat_inc(exp_fix);
         end
         ack_q.push_back(ack_t'{rd: 1'b1, dout: data_tbl[add], err: err_tbl[add]});
      end
      host_req = 1'b1;
      host_wr  = wr;
      host_add = add;
      host_din = din;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!host_ack && n < 20);
      host_req = 1'b0;
      check(wr ? "wr_ack_latency" : "rd_ack_latency", n, exp_lat);
      @(posedge clk); #1;
   endtask

   task automatic scrub_run(input int nsteps);
      int target;
      int n;
      for (int i = 0; i < nsteps; i++) begin
         strobe_q.push_back(strobe_t'{wr: 1'b0, add: exp_ptr, din: 8'h00});
         if (err_tbl[exp_ptr]) begin
            strobe_q.push_back(strobe_t'{wr: 1'b1, add: exp_ptr, din: data_tbl[exp_ptr]});
            exp_fix = sat_inc(exp_fix);
         end
         if (exp_ptr == 4'hF) exp_pass++;
         exp_ptr = exp_ptr + 1'b1;
      end
      target = srd_cnt + nsteps;
      run_id++;
      scrub_en = 1'b1;
      n = 0;
      while (srd_cnt < target && n < nsteps * PERIOD + 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      scrub_en = 1'b0;
      check("scrub_steps", srd_cnt, target);
      repeat (6) @(posedge clk);
      #1;
      check("scrub_sb_empty", strobe_q.size(), 0);
      check("scrub_fix_cnt", scrub_fix_cnt, exp_fix);
      check("scrub_pass_cnt", pass_cnt, exp_pass);
   endtask

   initial begin
      int target;
      int n;
      for (int i = 0; i < 16; i++) begin
         data_tbl[i] = 8'(8'h10 + i);
         err_tbl[i]  = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_host_ack", host_ack, 0);
      check("rst_host_dout", host_dout, 0);
      check("rst_busy", scrub_busy, 0);
      check("rst_fix_cnt", scrub_fix_cnt, 0);
      check("rst_pass", scrub_pass, 0);
      @(negedge clk) clr = 1'b1;
      @(posedge clk); #1;

      // Host write, clean read, then read with a corrected error.
      data_tbl[3] = 8'h44;
      host_txn(1'b1, 4'h3, 8'h44, 2);
      check("fix_after_write", scrub_fix_cnt, 0);
      host_txn(1'b0, 4'h3, 8'h00, RD_LAT + 2);
      check("dout_held", host_dout, 8'h44);
      data_tbl[1] = 8'h44;
      err_tbl[1]  = 1'b1;
      host_txn(1'b0, 4'h1, 8'h00, RD_LAT + 3);
      check("fix_after_host_wb", scrub_fix_cnt, 1);
      check("host_err_held", host_err, 1);
      err_tbl[1] = 1'b0;

      // Clean sweep 0..15,0.
      scrub_run(17);

      // Host request raised in the cycle after a scrub read strobe.
      strobe_q.push_back(strobe_t'{wr: 1'b0, add: exp_ptr, din: 8'h00});
      exp_ptr = exp_ptr + 1'b1;
      target = srd_cnt + 1;
      run_id++;
      scrub_en = 1'b1;
      n = 0;
      while (srd_cnt < target && n < PERIOD + 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      scrub_en = 1'b0;
      check("mid_scrub_read_seen", srd_cnt, target);
      // One cycle of S_WAIT still ahead, so the write acks one cycle late.
      host_txn(1'b1, 4'h9, 8'h3C, 3);
      check("mid_scrub_sb_empty", strobe_q.size(), 0);

      // Error at address 2 only: one writeback per sweep, then saturation.
      err_tbl[2]  = 1'b1;
      data_tbl[2] = 8'hA5;
      scrub_run(16);
      scrub_run(4080);
      check("fix_saturated", scrub_fix_cnt, 255);

      // Reset while the host read sits in H_WAIT.
      strobe_q.push_back(strobe_t'{wr: 1'b0, add: 4'h5, din: 8'h00});
      host_req = 1'b1;
      host_wr  = 1'b0;
      host_add = 4'h5;
      @(posedge clk);
      @(posedge clk); #1;
      clr      = 1'b0;
      host_req = 1'b0;
      #1;
      check("clr_mem_en", mem_en, 0);
      check("clr_host_ack", host_ack, 0);
      check("clr_host_dout", host_dout, 0);
      check("clr_host_err", host_err, 0);
      check("clr_fix_cnt", scrub_fix_cnt, 0);
      check("clr_busy", scrub_busy, 0);
      repeat (4) @(posedge clk);
      @(negedge clk) clr = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("clr_no_ack", host_ack, 0);
      check("clr_sb_empty", strobe_q.size(), 0);
      check("clr_ack_q_empty", ack_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
